// File: rtl/player_motion_if.sv
// Player motion bus: frame strobe, controls and collider bounds toward the
// mover; registered position, vertical speed and motion state back out.
// Modports: master = controller/collider side, slave = player_motion.
interface player_motion_if;
    logic              frame_clk;
    logic              key_left;
    logic              key_right;
    logic              key_jump;
    logic [9:0]        player_X_Min;
    logic [9:0]        player_X_Max;
    logic [9:0]        player_Y_Min;
    logic [9:0]        player_Y_Max;
    logic [9:0]        player_X_Pos;
    logic [9:0]        player_Y_Pos;
    logic signed [4:0] vel_y;
    logic [1:0]        motion_state;

    modport master (
        output frame_clk, key_left, key_right, key_jump,
        output player_X_Min, player_X_Max, player_Y_Min, player_Y_Max,
        input  player_X_Pos, player_Y_Pos, vel_y, motion_state
    );

    modport slave (
        input  frame_clk, key_left, key_right, key_jump,
        input  player_X_Min, player_X_Max, player_Y_Min, player_Y_Max,
        output player_X_Pos, player_Y_Pos, vel_y, motion_state
    );
endinterface

// File: rtl/player_motion.sv
// Platformer player mover: walk, jump, gravity, bounds clamping once per frame.
// Latency: one update on the Clk edge that ends the frame_clk rising-edge tick cycle.
// Backpressure: none; outputs hold between ticks, inputs sampled only in the tick cycle.
// Ports: Clk, Reset (sync, active-high), bus (player_motion_if.slave) carrying
//   frame_clk, key_left/right/jump, X/Y Min/Max bounds in and X/Y position,
//   vel_y (signed, negative = up), motion_state (00 GROUND, 01 RISE, 10 FALL) out.
// Optional: define DOUBLE_JUMP_EN to allow one extra jump while airborne.
module player_motion #(
    parameter int X_START = 32,
    parameter int Y_START = 415,
    parameter int STEP_X  = 2,
    parameter int JUMP_V  = 8,
    parameter int GRAVITY = 1,
    parameter int VMAX    = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    player_motion_if.slave bus
);
    localparam logic [1:0] ST_GROUND = 2'b00;
    localparam logic [1:0] ST_RISE   = 2'b01;
    localparam logic [1:0] ST_FALL   = 2'b10;

    localparam logic signed [11:0] STEP_S = 12'(STEP_X);
    localparam logic signed [11:0] JUMP_S = 12'(JUMP_V);
    localparam logic signed [11:0] GRAV_S = 12'(GRAVITY);
    localparam logic signed [11:0] VMAX_S = 12'(VMAX);
    localparam logic [9:0]         X_RST  = 10'(X_START);
    localparam logic [9:0]         Y_RST  = 10'(Y_START);

    logic              frame_q, frame_q2, tick;
    logic [9:0]        x_q, y_q;
    logic signed [4:0] vel_q;
    logic [1:0]        st_q, st_d;

    logic signed [11:0] x_w, y_w, v_w, dx, x_sum, x_ret;
    logic signed [11:0] x_min, x_max, y_min, y_max;
    logic signed [11:0] v_rise, y_rise, v_fall, y_fall, y_launch, y_jump;
    logic signed [11:0] y_ret, v_ret;

`ifdef DOUBLE_JUMP_EN
    logic jump_prev_q, dj_q, dj_d;
`endif

    // Final narrowing; the clamps above already keep results in range, this
    // only guarantees no wrap if bounds are ever violated.
    function automatic logic [9:0] sat10(input logic signed [11:0] v);
        if (v < 12'sd0)         sat10 = '0;
        else if (v > 12'sd1023) sat10 = '1;
        else                    sat10 = v[9:0];
    endfunction

    function automatic logic signed [4:0] sat5(input logic signed [11:0] v);
        if (v < -12'sd16)     sat5 = 5'sb10000;
        else if (v > 12'sd15) sat5 = 5'sd15;
        else                  sat5 = v[4:0];
    endfunction

    assign tick = frame_q & ~frame_q2;

    always_comb begin
        x_w   = $signed({2'b00, x_q});
        y_w   = $signed({2'b00, y_q});
        v_w   = $signed({{7{vel_q[4]}}, vel_q});
        x_min = $signed({2'b00, bus.player_X_Min});
        x_max = $signed({2'b00, bus.player_X_Max});
        y_min = $signed({2'b00, bus.player_Y_Min});
        y_max = $signed({2'b00, bus.player_Y_Max});

        // Horizontal: opposing keys cancel; an inverted window freezes X.
        dx = 12'sd0;
        if (bus.key_right && !bus.key_left)      dx = STEP_S;
        else if (bus.key_left && !bus.key_right) dx = -STEP_S;
        x_sum = x_w + dx;
        if (x_min > x_max)      x_ret = x_w;
        else if (x_sum < x_min) x_ret = x_min;
        else if (x_sum > x_max) x_ret = x_max;
        else                    x_ret = x_sum;

        // Candidate vertical moves; speed is updated before it is applied.
        v_rise   = v_w + GRAV_S;
        y_rise   = y_w + v_rise;
        v_fall   = (v_rise > VMAX_S) ? VMAX_S : v_rise;
        y_fall   = y_w + v_fall;
        y_launch = y_w - JUMP_S;
        y_jump   = (y_launch < y_min) ? y_min : y_launch;

        y_ret = y_w;
        v_ret = v_w;
        st_d  = st_q;
        case (st_q)
            ST_GROUND: begin
                v_ret = 12'sd0;
                if (bus.key_jump) begin
                    v_ret = -JUMP_S;
                    y_ret = y_jump;
                    st_d  = ST_RISE;
                end else if (y_w < y_max) begin
                    st_d = ST_FALL;
                end else begin
                    y_ret = y_max;
                end
            end
            ST_RISE: begin
                if (y_rise <= y_min) begin
                    v_ret = 12'sd0;
                    // Degenerate window: the floor takes priority.
                    if (y_min >= y_max) begin
                        y_ret = y_max;
                        st_d  = ST_GROUND;
                    end else begin
                        y_ret = y_min;
                        st_d  = ST_FALL;
                    end
                end else begin
                    y_ret = y_rise;
                    v_ret = v_rise;
                    if (v_rise >= 12'sd0) st_d = ST_FALL;
                end
            end
            ST_FALL: begin
                if (y_fall >= y_max) begin
                    y_ret = y_max;
                    v_ret = 12'sd0;
                    st_d  = ST_GROUND;
                end else begin
                    y_ret = y_fall;
                    v_ret = v_fall;
                end
            end
            default: begin
                v_ret = 12'sd0;
                st_d  = ST_FALL;
            end
        endcase

`ifdef DOUBLE_JUMP_EN
        // Extra jump needs a fresh press (edge across ticks) and is one-shot
        // until the player lands again.
        dj_d = dj_q;
        if ((st_q == ST_RISE || st_q == ST_FALL) && bus.key_jump &&
            !jump_prev_q && !dj_q) begin
            v_ret = -JUMP_S;
            y_ret = y_jump;
            st_d  = ST_RISE;
            dj_d  = 1'b1;
        end
        if (st_d == ST_GROUND) dj_d = 1'b0;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_q  <= 1'b0;
            frame_q2 <= 1'b0;
            x_q      <= X_RST;
            y_q      <= Y_RST;
            vel_q    <= 5'sd0;
            st_q     <= ST_GROUND;
`ifdef DOUBLE_JUMP_EN
            jump_prev_q <= 1'b0;
            dj_q        <= 1'b0;
`endif
        end else begin
            frame_q  <= bus.frame_clk;
            frame_q2 <= frame_q;
            if (tick) begin
                x_q   <= sat10(x_ret);
                y_q   <= sat10(y_ret);
                vel_q <= sat5(v_ret);
                st_q  <= st_d;
`ifdef DOUBLE_JUMP_EN
                jump_prev_q <= bus.key_jump;
                dj_q        <= dj_d;
`endif
            end
        end
    end

    assign bus.player_X_Pos = x_q;
    assign bus.player_Y_Pos = y_q;
    assign bus.vel_y        = vel_q;
    assign bus.motion_state = st_q;
endmodule
